// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 types and constants used by the KSA and decode stages
package rc4_pkg;

    localparam int S_SIZE                = 256;
    localparam int RC4_KEY_BYTES_DEFAULT = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_I_ADDR,
        ST_RD_I,
        ST_UPD_J,
        ST_RD_J_ADDR,
        ST_RD_J,
        ST_WR_I,
        ST_WR_J,
        ST_NEXT,
        ST_DONE
    } rc4_state_e;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// rc4_key_byte_sel: picks key byte kidx from a packed key, byte 0 being the MSB
module rc4_key_byte_sel #(
    parameter int KEY_BYTES = 3,
    parameter int KW        = 2
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [KW-1:0]          kidx,
    output logic [7:0]             key_byte
);

    // Mux over the key bytes; kidx counts in MSB-first order
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++)
            if (kidx == KW'(k)) key_byte = key[8*(KEY_BYTES-1-k) +: 8];
    end

endmodule

// File: rtl/rc4_ksa.sv
// rc4_ksa: RC4 key scheduling (identity init + KSA shuffle) on an external S memory.
// Optional macro RC4_KSA_SELF_SWAP_SKIP_EN skips the read/write of S[j] when j==i.
module rc4_ksa
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = RC4_KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             s_memory_address,
    output logic [7:0]             s_memory_data,
    output logic                   s_memory_write_enable,
    input  logic [7:0]             s_memory_q,
    output logic                   busy,
    output logic                   finish
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    rc4_state_e             state_q, state_d;
    logic [7:0]             i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]          kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             key_byte, j_sum;

    rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES), .KW(KW)) u_key_sel (
        .key      (key_q),
        .kidx     (kidx_q),
        .key_byte (key_byte)
    );

    assign j_sum = j_q + si_q + key_byte;

    // Next-state, register updates and memory-port outputs
    always_comb begin
        state_d               = state_q;
        i_d                   = i_q;
        j_d                   = j_q;
        si_d                  = si_q;
        sj_d                  = sj_q;
        kidx_d                = kidx_q;
        key_d                 = key_q;
        s_memory_address      = '0;
        s_memory_data         = '0;
        s_memory_write_enable = 1'b0;
        finish                = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                i_d     = '0;
                j_d     = '0;
                kidx_d  = '0;
                key_d   = secret_key;
                state_d = ST_INIT;
            end
            ST_INIT: begin
                s_memory_address      = i_q;
                s_memory_data         = i_q;
                s_memory_write_enable = 1'b1;
                i_d                   = i_q + 8'd1;
                if (i_q == 8'(S_SIZE-1)) state_d = ST_RD_I_ADDR;
            end
            ST_RD_I_ADDR: begin
                s_memory_address = i_q;
                state_d          = ST_RD_I;
            end
            ST_RD_I: begin
                s_memory_address = i_q;
                si_d             = s_memory_q;
                state_d          = ST_UPD_J;
            end
            ST_UPD_J: begin
                j_d = j_sum;
`ifdef RC4_KSA_SELF_SWAP_SKIP_EN
                state_d = (j_sum == i_q) ? ST_NEXT : ST_RD_J_ADDR;
`else
                state_d = ST_RD_J_ADDR;
`endif
            end
            ST_RD_J_ADDR: begin
                s_memory_address = j_q;
                state_d          = ST_RD_J;
            end
            ST_RD_J: begin
                s_memory_address = j_q;
                sj_d             = s_memory_q;
                state_d          = ST_WR_I;
            end
            ST_WR_I: begin
                s_memory_address      = i_q;
                s_memory_data         = sj_q;
                s_memory_write_enable = 1'b1;
                state_d               = ST_WR_J;
            end
            ST_WR_J: begin
                s_memory_address      = j_q;
                s_memory_data         = si_q;
                s_memory_write_enable = 1'b1;
                state_d               = ST_NEXT;
            end
            ST_NEXT: begin
                kidx_d = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
                if (i_q == 8'(S_SIZE-1)) state_d = ST_DONE;
                else begin
                    i_d     = i_q + 8'd1;
                    state_d = ST_RD_I_ADDR;
                end
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // State and datapath registers; reset aborts any run back to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: tb/tb_rc4_ksa.sv
// tb_rc4_ksa: scoreboard bench for rc4_ksa with a synchronous-read S memory model
module tb_rc4_ksa;

    typedef logic [255:0][7:0] img_t;
    typedef struct {
        img_t img;
        int   lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  addr, wdata, q;
    logic        we, busy, finish;

    logic [7:0]  mem [256];
    exp_t        exp_q [$];
    int          n_chk = 0, n_pass = 0;
    int          wr_cnt = 0, run_len = 0, last_len = 0;

    always #5 clk = ~clk;

    rc4_ksa dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start                 (start),
        .secret_key            (secret_key),
        .s_memory_address      (addr),
        .s_memory_data         (wdata),
        .s_memory_write_enable (we),
        .s_memory_q            (q),
        .busy                  (busy),
        .finish                (finish)
    );

    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        q <= mem[addr];
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic void ksa(input logic [23:0] k, output img_t s, output int lat);
        logic [7:0] j, t, kb;
        lat = 257;
        j   = 0;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            kb = k[8*(2 - n % 3) +: 8];
            j  = j + s[n] + kb;
`ifdef RC4_KSA_SELF_SWAP_SKIP_EN
            lat += (j == 8'(n)) ? 4 : 8;
`else
            lat += 8;
`endif
            t    = s[n];
            s[n] = s[j];
            s[j] = t;
        end
    endfunction

    // Monitor: counts busy cycles, write strobes, and scores each finish against the queue
    always @(negedge clk) begin
        exp_t e;
        int   bad, first;
        if (we) wr_cnt++;
        if (busy) run_len++;
        else run_len = 0;
        if (finish) begin
            last_len = run_len;
            if (exp_q.size() == 0) chk(1'b0, "unexpected_finish", 1, 0);
            else begin
                e     = exp_q.pop_front();
                bad   = 0;
                first = -1;
                for (int n = 0; n < 256; n++)
                    if (mem[n] !== e.img[n]) begin
                        bad++;
                        if (first < 0) first = n;
                    end
                chk(run_len == e.lat, "latency", run_len, e.lat);
                chk(bad == 0, "s_image_bad_bytes", bad, 0);
                if (first >= 0)
                    $display("  first bad S[%0d]: got %0d expected %0d", first, mem[first], e.img[first]);
            end
        end
    end

    task automatic run_start(input logic [23:0] k, input bit expect_done);
        exp_t e;
        ksa(k, e.img, e.lat);
        if (expect_done) exp_q.push_back(e);
        @(negedge clk);
        secret_key = k;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int c = 0;
        while (!finish && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (!finish) chk(1'b0, name, 0, 1);
    endtask

    initial begin
        int base, bad;
        #1;
        chk(addr == 0, "reset_addr", addr, 0);
        chk(wdata == 0, "reset_data", wdata, 0);
        chk(we == 0, "reset_we", we, 0);
        chk(busy == 0, "reset_busy", busy, 0);
        chk(finish == 0, "reset_finish", finish, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        base = wr_cnt;
        run_start(24'h000249, 1'b1);
        repeat (256) @(negedge clk);
        #1;
        bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== 8'(n)) bad++;
        chk(bad == 0, "identity_bad_bytes", bad, 0);
        chk(wr_cnt - base == 256, "init_writes", wr_cnt - base, 256);
        wait_finish("timeout_000249");
        @(negedge clk);
`ifndef RC4_KSA_SELF_SWAP_SKIP_EN
        chk(last_len == 2305, "latency_000249_const", last_len, 2305);
`endif

        run_start(24'h0A0B0C, 1'b1);
        repeat (600) @(negedge clk);
        secret_key = 24'h123456;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        secret_key = 24'hFFFFFF;
        wait_finish("timeout_ignore_start");
        @(negedge clk);

        run_start(24'hC0FFEE, 1'b0);
        repeat (256 + 8*100 - 1) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk(addr == 0, "abort_addr", addr, 0);
        chk(wdata == 0, "abort_data", wdata, 0);
        chk(we == 0, "abort_we", we, 0);
        chk(busy == 0, "abort_busy", busy, 0);
        #1 reset_n = 1'b1;
        run_start(24'h000249, 1'b1);
        wait_finish("timeout_after_abort");
        @(negedge clk);

        run_start(24'h000001, 1'b1);
        wait_finish("timeout_b2b_first");
        begin
            exp_t e;
            ksa(24'hFFFFFF, e.img, e.lat);
            exp_q.push_back(e);
        end
        secret_key = 24'hFFFFFF;
        start      = 1'b1;
        @(negedge clk);
        chk(busy == 0, "b2b_idle_gap", busy, 0);
        @(negedge clk);
        start = 1'b0;
        chk(busy == 1, "b2b_accepted", busy, 1);
        wait_finish("timeout_b2b_second");
        @(negedge clk);

        run_start(24'h000000, 1'b1);
        wait_finish("timeout_key0");
        @(negedge clk);
`ifdef RC4_KSA_SELF_SWAP_SKIP_EN
        chk(last_len <= 2301, "latency_key0_skip", last_len, 2301);
`else
        chk(last_len == 2305, "latency_key0", last_len, 2305);
`endif

        repeat (4) @(negedge clk);
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
